// File: rtl/ip_fifo_rd_stage.sv
// ip_fifo_rd_stage: FIFO read-side skid stage turning pop/rdata into a valid/ready stream.
// Define IP_FIFO_RD_STAT_EN to enable the saturating backpressure stall counter.
module ip_fifo_rd_stage #(
   parameter int DWID   = 32,
   parameter int RD_LAT = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            ff_empty,
   input  logic [DWID-1:0] rdata,
   input  logic            flush,
   output logic            pop,
   output logic            rflush,
   output logic            dout_vld,
   output logic [DWID-1:0] dout,
   input  logic            dout_rdy,
   output logic [1:0]      stage_lvl,
   output logic [15:0]     stall_cnt
);
   localparam int BUF_DEP = RD_LAT + 1;
   localparam int IW = $clog2(BUF_DEP);
   logic [DWID-1:0] buf_q [BUF_DEP];
   logic [IW-1:0] wr_idx, rd_idx;
   logic [RD_LAT-1:0] pipe;
   logic [1:0] infl;
   logic [2:0] occ;
   logic fire, cap;
   function automatic logic [IW-1:0] nxt(input logic [IW-1:0] i);
      return i == IW'(BUF_DEP - 1) ? '0 : i + 1'b1;
   endfunction
   always_comb begin
      infl = '0;
      for (int i = 0; i < RD_LAT; i++) infl = infl + 2'(pipe[i]);
   end
   assign fire = dout_vld & dout_rdy;
   assign cap = pipe[RD_LAT-1];
   assign dout_vld = stage_lvl != 2'd0;
   assign dout = buf_q[rd_idx];
   assign rflush = flush;
   // a word leaving this cycle frees its slot for a pop issued in the same cycle
   assign occ = 3'(stage_lvl) + 3'(infl);
   assign pop = ~rst & ~flush & ~ff_empty & (occ < 3'(BUF_DEP) + 3'(fire));
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         pipe <= '0;
         wr_idx <= '0;
         rd_idx <= '0;
         stage_lvl <= '0;
         for (int i = 0; i < BUF_DEP; i++) buf_q[i] <= '0;
      end else begin
         pipe <= RD_LAT'({pipe, pop});
         if (cap) begin
            buf_q[wr_idx] <= rdata;
            wr_idx <= nxt(wr_idx);
         end
         if (fire) rd_idx <= nxt(rd_idx);
         stage_lvl <= stage_lvl + 2'(cap) - 2'(fire);
      end
   end
`ifdef IP_FIFO_RD_STAT_EN
   always_ff @(posedge clk) begin
      if (rst || flush) stall_cnt <= '0;
      else if (dout_vld && !dout_rdy && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
   end
`else
   assign stall_cnt = 16'h0;
`endif
endmodule

// File: tb/tb_ip_fifo_rd_stage.sv
// tb_ip_fifo_rd_stage: runs RD_LAT=1 and RD_LAT=2 lanes side by side against a queue-based model.
module tb_ip_fifo_rd_stage;
`ifdef IP_FIFO_RD_STAT_EN
   localparam int STAT = 1;
`else
   localparam int STAT = 0;
`endif
   typedef struct { logic [31:0] d; int t; } ent_t;
   logic clk = 0, rst = 1, flush = 0, rdy = 1;
   int push_n = 0;
   logic [31:0] words [8];
   logic [1:0] pop_v, rflush_v, vld_v;
   logic [1:0][31:0] dout_v;
   logic [1:0][1:0] lvl_v;
   logic [1:0][15:0] stall_v;
   int errors = 0, checks = 0;

   always #5 clk = ~clk;

   task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", n, got, exp, $time);
      end
   endtask

   for (genvar l = 0; l < 2; l++) begin : g_lane
      localparam int LAT = l + 1;
      localparam int DEP = LAT + 1;
      logic ff_empty;
      logic [31:0] rdata;
      logic empty_nx = 1;
      logic [31:0] rd_nx = 0;
      logic [31:0] dl [LAT];
      logic [31:0] fq [$];
      ent_t arr [$];
      int cyc = 0, stall_e = 0;
      ip_fifo_rd_stage #(.DWID(32), .RD_LAT(LAT)) dut (
         .clk(clk), .rst(rst), .ff_empty(ff_empty), .rdata(rdata), .flush(flush),
         .pop(pop_v[l]), .rflush(rflush_v[l]), .dout_vld(vld_v[l]), .dout(dout_v[l]),
         .dout_rdy(rdy), .stage_lvl(lvl_v[l]), .stall_cnt(stall_v[l]));
      always @(posedge clk) begin
         ff_empty <= empty_nx;
         rdata <= rd_nx;
      end
      always @(negedge clk) begin
         int lv, inf;
         logic v, f, p;
         ent_t e;
         lv = 0;
         inf = 0;
         foreach (arr[i]) if (arr[i].t <= cyc) lv++; else inf++;
         v = lv != 0;
         f = v & rdy;
         p = !rst && !flush && !ff_empty && (lv + inf - int'(f) < DEP);
         chk($sformatf("L%0d pop", l), pop_v[l], p);
         chk($sformatf("L%0d rflush", l), rflush_v[l], flush);
         chk($sformatf("L%0d dout_vld", l), vld_v[l], v);
         chk($sformatf("L%0d stage_lvl", l), lvl_v[l], lv);
         chk($sformatf("L%0d stall_cnt", l), stall_v[l], stall_e * STAT);
         chk($sformatf("L%0d invariant", l), int'(lvl_v[l]) + inf <= DEP, 1);
         if (v) chk($sformatf("L%0d dout", l), dout_v[l], arr[0].d);
         for (int k = LAT - 1; k > 0; k--) dl[k] = dl[k-1];
         dl[0] = p ? fq[0] : $urandom;
         if (rst || flush) begin
            arr.delete();
            stall_e = 0;
         end else begin
            if (f) void'(arr.pop_front());
            if (v && !rdy && stall_e != 65535) stall_e++;
            if (p) begin
               e.d = fq.pop_front();
               e.t = cyc + LAT + 1;
               arr.push_back(e);
            end
         end
         if (flush) fq.delete();
         for (int k = 0; k < push_n; k++) fq.push_back(words[k]);
         empty_nx = fq.size() == 0;
         rd_nx = dl[LAT-1];
         cyc++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      push_n = 0;
   endtask

   task automatic fill(input int n);
      for (int k = 0; k < n; k++) words[k] = $urandom;
      push_n = n;
   endtask

   task automatic burst(input int n, input int fp_e, input int ncyc);
      int fp [2], fv [2], cnt [2], lf [2];
      for (int l = 0; l < 2; l++) begin
         fp[l] = -1; fv[l] = -1; cnt[l] = 0; lf[l] = -1;
      end
      for (int c = 0; c < ncyc; c++) begin
         @(negedge clk);
         for (int l = 0; l < 2; l++) begin
            if (pop_v[l] && fp[l] < 0) fp[l] = c;
            if (vld_v[l] && fv[l] < 0) fv[l] = c;
            if (vld_v[l] && rdy) begin
               if (cnt[l] < n) chk($sformatf("L%0d burst word%0d", l, cnt[l]), dout_v[l], words[cnt[l]]);
               cnt[l]++;
               lf[l] = c;
            end
         end
         tick();
      end
      for (int l = 0; l < 2; l++) begin
         chk($sformatf("L%0d first pop cycle", l), fp[l], fp_e);
         chk($sformatf("L%0d pop to valid", l), fv[l] - fp[l], l + 2);
         chk($sformatf("L%0d fire count", l), cnt[l], n);
         chk($sformatf("L%0d gapless", l), lf[l] - fv[l], n - 1);
      end
   endtask

   initial begin
      int pops [2];
      // reset state
      @(negedge clk);
      for (int l = 0; l < 2; l++) begin
         chk($sformatf("L%0d reset vld", l), vld_v[l], 0);
         chk($sformatf("L%0d reset lvl", l), lvl_v[l], 0);
         chk($sformatf("L%0d reset dout", l), dout_v[l], 0);
         chk($sformatf("L%0d reset stall", l), stall_v[l], 0);
      end
      tick(); fill(4);
      tick();
      @(negedge clk);
      for (int l = 0; l < 2; l++) chk($sformatf("L%0d pop in rst", l), pop_v[l], 0);
      tick(); rst = 0;
      burst(4, 0, 12);
      // backpressure: 5 stalled cycles once both lanes are streaming
      fill(10);
      repeat (4) tick();
      tick(); rdy = 0;
      pops = '{0, 0};
      for (int s = 0; s < 5; s++) begin
         @(negedge clk);
         for (int l = 0; l < 2; l++) begin
            chk($sformatf("L%0d held dout", l), dout_v[l], words[2-l]);
            pops[l] += int'(pop_v[l]);
         end
         tick();
      end
      rdy = 1;
      @(negedge clk);
      for (int l = 0; l < 2; l++) begin
         chk($sformatf("L%0d stall after 5", l), stall_v[l], 5 * STAT);
         chk($sformatf("L%0d full lvl", l), lvl_v[l], l + 2);
         chk($sformatf("L%0d pops while stalled", l), pops[l] <= l + 2, 1);
      end
      // flush mid-stream with words buffered and in flight
      tick();
      tick(); flush = 1;
      @(negedge clk);
      for (int l = 0; l < 2; l++) begin
         chk($sformatf("L%0d flush rflush", l), rflush_v[l], 1);
         chk($sformatf("L%0d flush pop", l), pop_v[l], 0);
      end
      tick(); flush = 0;
      for (int s = 0; s < 6; s++) begin
         @(negedge clk);
         for (int l = 0; l < 2; l++) chk($sformatf("L%0d post-flush vld", l), vld_v[l], 0);
         tick();
      end
      fill(3);
      burst(3, 1, 10);
      fill(8);
      burst(8, 1, 16);
      // reset mid-stream with a full stage
      rdy = 0; fill(5);
      repeat (8) tick();
      @(negedge clk);
      for (int l = 0; l < 2; l++) chk($sformatf("L%0d pre-rst lvl", l), lvl_v[l], l + 2);
      tick(); rst = 1;
      @(negedge clk);
      for (int l = 0; l < 2; l++) chk($sformatf("L%0d pop at rst", l), pop_v[l], 0);
      tick();
      @(negedge clk);
      for (int l = 0; l < 2; l++) begin
         chk($sformatf("L%0d rst vld", l), vld_v[l], 0);
         chk($sformatf("L%0d rst lvl", l), lvl_v[l], 0);
         chk($sformatf("L%0d rst dout", l), dout_v[l], 0);
         chk($sformatf("L%0d rst stall", l), stall_v[l], 0);
         chk($sformatf("L%0d rst pop", l), pop_v[l], 0);
      end
      tick(); rst = 0; rdy = 1;
      repeat (10) tick();
      // random traffic: toggling ff_empty, random ready, rare flush
      for (int c = 0; c < 600; c++) begin
         tick();
         rdy = $urandom_range(0, 3) != 0;
         flush = $urandom_range(0, 79) == 0;
         if (!flush && c % 2 == 0) begin
            words[0] = $urandom;
            push_n = 1;
         end
      end
      tick(); flush = 0; rdy = 1;
      repeat (30) tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
